// File: rtl/temp_sampler.sv
// temp_sampler: averages 2^LOG2_AVG raw ADC readings, applies offset/gain
// calibration, saturates to signed Q7.0 and flags restart samples with init.
// A watchdog declares sensor_fault when no sample arrives for TIMEOUT cycles.
module temp_sampler #(
    parameter int unsigned LOG2_AVG = 2,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] adc_data,
    input  logic        adc_valid,
    output logic        adc_ready,
    input  logic [11:0] offset,
    input  logic [7:0]  gain,
    input  logic        resync,
    output logic [7:0]  T_cur,
    output logic        t_valid,
    output logic        init,
    output logic        t_sat,
    output logic        sensor_fault
);

    localparam int unsigned AW = 12 + LOG2_AVG;
    localparam int unsigned CW = LOG2_AVG + 1;
    localparam int unsigned N  = 1 << LOG2_AVG;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_CALC  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   wd_q, wd_d;
    logic          first_q, first_d;
    logic [7:0]    t_cur_q, t_cur_d;
    logic          t_valid_q, t_valid_d;
    logic          init_q, init_d;
    logic          t_sat_q, t_sat_d;
    logic          fault_q, fault_d;

    logic               accept;
    logic [11:0]        avg;
    logic signed [12:0] diff;
    logic signed [8:0]  gain_s;
    logic signed [21:0] prod;
    logic signed [15:0] t_scaled;
    logic [7:0]         t_clamped;
    logic               t_clip;

    assign adc_ready = (state_q != ST_CALC) && !rst;
    assign accept    = adc_valid && adc_ready;

    // Calibration datapath: average, subtract offset, scale by Q2.6 gain, clamp to Q7.0
    always_comb begin
        avg      = acc_q[AW-1:LOG2_AVG];
        diff     = $signed({1'b0, avg}) - $signed({1'b0, offset});
        gain_s   = $signed({1'b0, gain});
        prod     = diff * gain_s;
        t_scaled = prod[21:6];
        if (t_scaled > 16'sd127) begin
            t_clamped = 8'h7f;
            t_clip    = 1'b1;
        end else if (t_scaled < -16'sd128) begin
            t_clamped = 8'h80;
            t_clip    = 1'b1;
        end else begin
            t_clamped = t_scaled[7:0];
            t_clip    = 1'b0;
        end
    end

    // Next-state and output logic for the ACC / CALC / FAULT controller
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        first_d   = first_q;
        t_cur_d   = t_cur_q;
        t_valid_d = 1'b0;
        init_d    = 1'b0;
        t_sat_d   = 1'b0;
        fault_d   = fault_q;
        case (state_q)
            ST_ACC: begin
                if (resync) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                    first_d = 1'b1;
                end else if (accept) begin
                    acc_d = acc_q + {{LOG2_AVG{1'b0}}, adc_data};
                    cnt_d = cnt_q + 1'b1;
                    wd_d  = '0;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_CALC;
                    end
                end else if (wd_q == 16'(TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_CALC: begin
                t_cur_d   = t_clamped;
                t_sat_d   = t_clip;
                t_valid_d = 1'b1;
                // A resync landing on the compute cycle still tags this result as a restart
                init_d    = first_q | resync;
                first_d   = 1'b0;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = ST_ACC;
            end
            ST_FAULT: begin
                if (resync) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                    first_d = 1'b1;
                end else if (accept) begin
                    fault_d = 1'b0;
                    acc_d   = {{LOG2_AVG{1'b0}}, adc_data};
                    cnt_d   = CW'(1);
                    wd_d    = '0;
                    first_d = 1'b1;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            first_q   <= 1'b1;
            t_cur_q   <= '0;
            t_valid_q <= 1'b0;
            init_q    <= 1'b0;
            t_sat_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            first_q   <= first_d;
            t_cur_q   <= t_cur_d;
            t_valid_q <= t_valid_d;
            init_q    <= init_d;
            t_sat_q   <= t_sat_d;
            fault_q   <= fault_d;
        end
    end

    assign T_cur        = t_cur_q;
    assign t_valid      = t_valid_q;
    assign init         = init_q;
    assign t_sat        = t_sat_q;
    assign sensor_fault = fault_q;

endmodule
